// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared state, opcode/funct, ALU and mux-select encodings
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BEQ,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_REG = 1'b1;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // Quiescent control word: every enable and select low, ALU adding.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c           = '0;
    c.alu_ctrl  = ALU_ADD;
    c.alu_src_a = SRCA_PC;
    c.alu_src_b = SRCB_REG;
    c.pc_src    = PC_ALU;
    return c;
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: R-type funct field to ALU operation, flags unsupported funct
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_bad
);

  // Unknown funct falls back to add and raises the bad flag.
  always_comb begin
    o_alu_ctrl = i_funct == FN_SUB ? ALU_SUB :
                 i_funct == FN_AND ? ALU_AND :
                 i_funct == FN_OR  ? ALU_OR  :
                 i_funct == FN_SLT ? ALU_SLT : ALU_ADD;
    o_bad      = !(i_funct == FN_ADD || i_funct == FN_SUB || i_funct == FN_AND ||
                   i_funct == FN_OR  || i_funct == FN_SLT);
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: MIPS-style multicycle control FSM (fetch/decode/execute/memory/writeback)
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;
  logic [2:0] w_dec_ctrl;
  logic       w_dec_bad;

  alu_decoder u_alu_decoder (
    .i_funct    (funct),
    .o_alu_ctrl (w_dec_ctrl),
    .o_bad      (w_dec_bad)
  );

  // State register; reset parks the FSM in FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state: memory states stall on mem_ready, DECODE dispatches on opcode.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR  :
                          opcode == OP_RTYPE                   ? S_EXECUTE :
                          opcode == OP_BEQ                     ? S_BEQ     :
                          opcode == OP_ADDI                    ? S_ADDIEX  :
                          opcode == OP_J                       ? S_JUMP    : S_FETCH;
      S_MEMADR:  w_next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state control word; anything not named stays at the idle value.
  always_comb begin
    w_ctrl = ctrl_idle();
    case (r_state)
      S_FETCH: begin
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.illegal   = !is_legal_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alu_src_a = SRCA_REG;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: w_ctrl.iord = 1'b1;
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        w_ctrl.alu_src_a = SRCA_REG;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_ctrl  = w_dec_ctrl;
        w_ctrl.illegal   = w_dec_bad;
      end
      S_ALUWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alu_src_a = SRCA_REG;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_ctrl  = ALU_SUB;
        w_ctrl.branch    = 1'b1;
        w_ctrl.pc_src    = PC_ALUOUT;
      end
      S_ADDIWB: w_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        w_ctrl.pc_src   = PC_JUMP;
        w_ctrl.pc_write = 1'b1;
      end
      default: w_ctrl = ctrl_idle();
    endcase
  end

  // Holding reset forces the idle word so no enable can leak out while rst_n is low.
  assign w_out      = rst_n ? w_ctrl : ctrl_idle();
  assign alu_ctrl   = w_out.alu_ctrl;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign pc_src     = w_out.pc_src;
  assign pc_en      = w_out.pc_write | (w_out.branch & zero);
  assign ir_write   = w_out.ir_write;
  assign mem_write  = w_out.mem_write;
  assign reg_write  = w_out.reg_write;
  assign iord       = w_out.iord;
  assign reg_dst    = w_out.reg_dst;
  assign mem_to_reg = w_out.mem_to_reg;
  assign illegal    = w_out.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench with per-instruction reference sequences
module tb_multicycle_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic [2:0] alu_ctrl;
  logic       alu_src_a, pc_en, ir_write, mem_write, reg_write, iord, reg_dst, mem_to_reg, illegal;
  logic [1:0] alu_src_b, pc_src;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] ac;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pe, ir, mw, rw, io, rd, mr, il;
  } o_t;

  o_t act, mon_e;
  o_t q[$];
  int total = 0, bad = 0;

  assign act = {alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, mem_write,
                reg_write, iord, reg_dst, mem_to_reg, illegal};

  task automatic chk(input string nm, input o_t a, input o_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Monitor: each cycle the DUT presents a control word, compare it to the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk($sformatf("cycle@%0t", $time), act, mon_e);
    end
  end

  function automatic o_t d();
    o_t e;
    e    = '0;
    e.ac = 3'b010;
    return e;
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op == RT || op == LW || op == SW || op == BQ || op == AI || op == JP;
  endfunction

  // {illegal, alu_ctrl} for an R-type funct field
  function automatic logic [3:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0_010;
      6'b100010: return 4'b0_110;
      6'b100100: return 4'b0_000;
      6'b100101: return 4'b0_001;
      6'b101010: return 4'b0_111;
      default:   return 4'b1_010;
    endcase
  endfunction

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr, input o_t e);
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int w);
    o_t e;
    e = d(); e.sb = 2'b01;
    repeat (w) cyc(r6(), r6(), rb(), 1'b0, e);
    e.ir = 1'b1; e.pe = 1'b1;
    cyc(r6(), r6(), rb(), 1'b1, e);
  endtask

  // One whole instruction: fw fetch stalls, mw memory stalls, z the zero flag during BEQ.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input logic z);
    o_t e;
    logic [3:0] a;
    fetch(fw);
    e = d(); e.sb = 2'b11; e.il = !legal(op);
    cyc(op, r6(), rb(), rb(), e);
    if (op == LW || op == SW) begin
      e = d(); e.sa = 1'b1; e.sb = 2'b10;
      cyc(op, r6(), rb(), rb(), e);
      e = d(); e.io = 1'b1; e.mw = (op == SW);
      repeat (mw) cyc(r6(), r6(), rb(), 1'b0, e);
      cyc(r6(), r6(), rb(), 1'b1, e);
      if (op == LW) begin
        e = d(); e.rw = 1'b1; e.mr = 1'b1;
        cyc(r6(), r6(), rb(), rb(), e);
      end
    end else if (op == RT) begin
      a = ref_alu(fn);
      e = d(); e.sa = 1'b1; e.ac = a[2:0]; e.il = a[3];
      cyc(op, fn, rb(), rb(), e);
      e = d(); e.rw = 1'b1; e.rd = 1'b1;
      cyc(r6(), r6(), rb(), rb(), e);
    end else if (op == BQ) begin
      e = d(); e.sa = 1'b1; e.ac = 3'b110; e.ps = 2'b01; e.pe = z;
      cyc(r6(), r6(), z, rb(), e);
    end else if (op == AI) begin
      e = d(); e.sa = 1'b1; e.sb = 2'b10;
      cyc(op, r6(), rb(), rb(), e);
      e = d(); e.rw = 1'b1;
      cyc(r6(), r6(), rb(), rb(), e);
    end else if (op == JP) begin
      e = d(); e.ps = 2'b10; e.pe = 1'b1;
      cyc(r6(), r6(), rb(), rb(), e);
    end
  endtask

  // Store aborted by reset while stalled in the memory write.
  task automatic sw_reset();
    o_t e;
    fetch(0);
    e = d(); e.sb = 2'b11;
    cyc(SW, r6(), rb(), rb(), e);
    e = d(); e.sa = 1'b1; e.sb = 2'b10;
    cyc(SW, r6(), rb(), rb(), e);
    e = d(); e.io = 1'b1; e.mw = 1'b1;
    cyc(r6(), r6(), rb(), 1'b0, e);
    opcode = r6(); mem_ready = 1'b0;
    q.push_back(e);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("sw_async_reset", act, d());
    @(posedge clk); #1;
    cyc(r6(), r6(), rb(), 1'b1, d());
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    ops = '{RT, LW, SW, BQ, AI, JP, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    mem_ready = 1'b1; opcode = LW;
    #1;
    chk("reset_outputs", act, d());
    @(posedge clk); #1;
    cyc(r6(), r6(), rb(), 1'b1, d());
    rst_n = 1'b1;
    run(RT, 6'b100000, 0, 0, 1'b0);
    run(LW, r6(), 0, 2, 1'b0);
    run(BQ, r6(), 0, 0, 1'b1);
    run(BQ, r6(), 0, 0, 1'b0);
    run(6'b111111, r6(), 0, 0, 1'b0);
    run(RT, 6'b011111, 1, 0, 1'b0);
    sw_reset();
    run(SW, r6(), 2, 1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 6)];
      if (op == 6'b111111) op = r6();
      fn = fns[$urandom_range(0, 5)];
      if (fn == 6'b000000) fn = r6();
      run(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb());
    end
    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, ports clk and rst_n.
REQ-002 The block SHALL have no parameters.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 opcode  in  6  instruction[31:26] from instruction register.
REQ-006 funct  in  6  instruction[5:0].
REQ-007 zero  in  1  ALU zero flag, same cycle.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 alu_ctrl  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 alu_src_a  out  1  0=PC, 1=register A.
REQ-011 alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-012 pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-013 pc_en  out  1  PC load enable.
REQ-014 ir_write, mem_write, reg_write  out  1 each  write enables.
REQ-015 iord, reg_dst, mem_to_reg  out  1 each  mux selects.
REQ-016 illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-017 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP.
REQ-018 Outputs SHALL default to 0 with alu_ctrl=010 in every state unless listed below.
REQ-019 FETCH: alu_src_b=01; ir_write and pc_write asserted only when mem_ready=1; state held while mem_ready=0.
REQ-020 DECODE: alu_src_b=11; next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JUMP, other -> FETCH with illegal=1.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10; next MEMRD if opcode=100011, else MEMWR.
REQ-022 MEMRD: iord=1; held until mem_ready=1, then MEMWB.
REQ-023 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-024 MEMWR: iord=1, mem_write=1 for every cycle in state; held until mem_ready=1, then FETCH.
REQ-025 EXECUTE: alu_src_a=1, alu_src_b=00; alu_ctrl from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010 with illegal=1; next ALUWB.
REQ-026 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-027 BEQ: alu_src_a=1, alu_src_b=00, alu_ctrl=110, branch=1, pc_src=01; next FETCH.
REQ-028 ADDIEX: alu_src_a=1, alu_src_b=10; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0; next FETCH.
REQ-029 JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-030 pc_en SHALL equal pc_write OR (branch AND zero), combinationally.
REQ-031 Latencies with mem_ready=1 SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-032 opcode/funct SHALL be sampled only in DECODE/MEMADR/EXECUTE; changes elsewhere have no effect.

Reset
REQ-033 rst_n=0 SHALL force state to FETCH immediately, regardless of clk.
REQ-034 While rst_n=0, all enables (pc_en, ir_write, mem_write, reg_write) and illegal SHALL be 0, all selects 0, alu_ctrl=010.
REQ-035 Reset mid-instruction SHALL abort it with no further write enable asserted; first FETCH follows rst_n release edge.

Structure
REQ-036 A shared package SHALL hold the state enum, opcode/funct constants, alu_ctrl and mux-select encodings.
REQ-037 One sub-module, alu_decoder (funct -> alu_ctrl, combinational), SHALL be instantiated.

Verification
REQ-038 add: opcode 000000, funct 100000, mem_ready=1 -> FETCH,DECODE,EXECUTE(alu_ctrl=010),ALUWB(reg_write=1,reg_dst=1), back to FETCH at cycle 5.
REQ-039 lw, mem_ready=0 for 2 cycles in MEMRD -> 7 cycles total, MEMWB has mem_to_reg=1, reg_write=1.
REQ-040 beq: zero=1 -> pc_en=1 in BEQ; zero=0 -> pc_en=0, pc_src=01 in both.
REQ-041 opcode 111111 -> illegal=1 for exactly the DECODE cycle, then FETCH, no write enable asserted.
REQ-042 sw, rst_n low mid-MEMWR -> mem_write drops asynchronously, state FETCH after release.
